// File: rtl/game_sequencer_if.sv
// game_sequencer_if: player inputs, datapath commands and display/status lines of the game sequencer
interface game_sequencer_if;
   logic mode, pose, Left, Right, hit;
   logic fall_en, move_left, move_right, field_clear, beep, show_win, show_lose;
   logic [3:0] minute, sec;
   logic [2:0] Life, state;
   modport master (
      input mode, pose, Left, Right, hit,
      output fall_en, move_left, move_right, field_clear, beep, show_win, show_lose, minute, sec, Life, state
   );
   modport slave (
      output mode, pose, Left, Right, hit,
      input fall_en, move_left, move_right, field_clear, beep, show_win, show_lose, minute, sec, Life, state
   );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: move/second tick dividers, BCD game timer, lives and READY/PLAY/PAUSE/HIT/WIN/LOSE control
module game_sequencer #(
   parameter int MV_DIV    = 3500000,
   parameter int SEC_DIV   = 25000000,
   parameter int HIT_TICKS = 4,
   parameter int CD_TENS   = 3
) (
   input logic CLK,
   input logic clear,
   game_sequencer_if.master bus
);
   localparam int MW = $clog2(MV_DIV);
   localparam int SW = $clog2(SEC_DIV);
   localparam int HW = $clog2(HIT_TICKS + 1);
   typedef enum logic [2:0] {READY = 3'd0, PLAY, PAUSE, HIT, WIN, LOSE} state_t;
   state_t st;
   logic [MW-1:0] mv_cnt;
   logic [SW-1:0] sec_cnt;
   logic [HW-1:0] hit_cnt;
   logic [1:0] lives, pose_sy, left_sy, right_sy;
   logic mode_q, run, mv_tick, sec_tick, at_zero, last_hit;
   logic [3:0] nx_min, nx_sec;
   assign bus.state = st;
   always_comb begin
      run = st == PLAY || st == HIT;
      mv_tick = run && mv_cnt == MW'(MV_DIV - 1);
      sec_tick = run && sec_cnt == SW'(SEC_DIV - 1);
      at_zero = mode_q && bus.minute == 4'd0 && bus.sec == 4'd0;
      last_hit = bus.hit && lives == 2'd1;
      nx_sec = mode_q ? (bus.sec == 4'd0 ? 4'd9 : bus.sec - 4'd1) : (bus.sec == 4'd9 ? 4'd0 : bus.sec + 4'd1);
      nx_min = mode_q ? (bus.sec == 4'd0 ? bus.minute - 4'd1 : bus.minute)
                      : (bus.sec == 4'd9 ? (bus.minute == 4'd9 ? 4'd0 : bus.minute + 4'd1) : bus.minute);
   end
   always_ff @(posedge CLK) begin
      if (clear) begin
         st <= READY;
         lives <= 2'd3;
         bus.Life <= 3'b111;
         mv_cnt <= '0;
         sec_cnt <= '0;
         hit_cnt <= '0;
         {pose_sy, left_sy, right_sy} <= '0;
         {bus.fall_en, bus.move_left, bus.move_right, bus.field_clear} <= '0;
         {bus.beep, bus.show_win, bus.show_lose} <= '0;
         mode_q <= bus.mode;
         bus.minute <= bus.mode ? 4'(CD_TENS) : 4'd0;
         bus.sec <= bus.mode ? 4'd0 : 4'd1;
      end else begin
         pose_sy <= {pose_sy[0], bus.pose};
         left_sy <= {left_sy[0], bus.Left};
         right_sy <= {right_sy[0], bus.Right};
         {bus.fall_en, bus.move_left, bus.move_right, bus.field_clear} <= '0;
         if (run) begin
            mv_cnt <= mv_tick ? '0 : mv_cnt + 1'b1;
            sec_cnt <= sec_tick ? '0 : sec_cnt + 1'b1;
         end
         if (sec_tick && !at_zero) {bus.minute, bus.sec} <= {nx_min, nx_sec};
         case (st)
            READY: begin
               bus.field_clear <= 1'b1;
               st <= PLAY;
            end
            PLAY, HIT: begin
               // A life-ending hit outranks the countdown win; an ordinary hit does not.
               if (last_hit) begin
                  st <= LOSE;
                  lives <= 2'd0;
                  bus.Life <= 3'b000;
                  bus.show_lose <= 1'b1;
                  bus.beep <= 1'b0;
                  bus.field_clear <= 1'b1;
               end else if (at_zero) begin
                  st <= WIN;
                  bus.show_win <= 1'b1;
                  bus.beep <= 1'b0;
               end else if (bus.hit) begin
                  st <= HIT;
                  lives <= lives - 2'd1;
                  bus.Life <= {1'b1, lives[0], 1'b0};
                  hit_cnt <= '0;
                  bus.beep <= 1'b1;
                  bus.field_clear <= 1'b1;
               end else if (st == HIT) begin
                  if (mv_tick && hit_cnt == HW'(HIT_TICKS - 1)) begin
                     st <= PLAY;
                     bus.beep <= 1'b0;
                  end else if (mv_tick) hit_cnt <= hit_cnt + 1'b1;
               end else if (pose_sy[1]) st <= PAUSE;
               else if (mv_tick) begin
                  bus.fall_en <= 1'b1;
                  bus.move_left <= left_sy[1] & ~right_sy[1];
                  bus.move_right <= right_sy[1] & ~left_sy[1];
               end
            end
            PAUSE: if (!pose_sy[1]) st <= PLAY;
            default: ;
         endcase
      end
   end
endmodule
